// File: rtl/chess_pkg.sv
// Shared constants for the board evaluator: piece ID ranges, material values,
// host register offsets and the evaluator FSM state type.
package chess_pkg;

  localparam logic [7:0] EMPTY     = 8'd0;
  localparam logic [7:0] PAWN_LO   = 8'd1;
  localparam logic [7:0] PAWN_HI   = 8'd8;
  localparam logic [7:0] ROOK_LO   = 8'd9;
  localparam logic [7:0] ROOK_HI   = 8'd18;
  localparam logic [7:0] KNIGHT_LO = 8'd19;
  localparam logic [7:0] KNIGHT_HI = 8'd28;
  localparam logic [7:0] BISHOP_LO = 8'd29;
  localparam logic [7:0] BISHOP_HI = 8'd38;
  localparam logic [7:0] QUEEN_LO  = 8'd39;
  localparam logic [7:0] QUEEN_HI  = 8'd47;
  localparam logic [7:0] KING_ID   = 8'd48;

  localparam logic signed [31:0] PAWN_VAL   = 32'sd100;
  localparam logic signed [31:0] ROOK_VAL   = 32'sd500;
  localparam logic signed [31:0] KNIGHT_VAL = 32'sd320;
  localparam logic signed [31:0] BISHOP_VAL = 32'sd330;
  localparam logic signed [31:0] QUEEN_VAL  = 32'sd900;
  localparam logic signed [31:0] KING_VAL   = 32'sd20000;

  localparam logic [3:0] REG_CTRL       = 4'd0;
  localparam logic [3:0] REG_BOARD_BASE = 4'd1;
  localparam logic [3:0] REG_SCORE_BASE = 4'd2;
  localparam logic [3:0] REG_COUNT      = 4'd3;
  localparam logic [3:0] REG_BEST_SCORE = 4'd4;
  localparam logic [3:0] REG_BEST_IDX   = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_ACCUM,
    S_WR_REQ,
    S_NEXT,
    S_DONE
  } state_e;

endpackage

// File: rtl/piece_value_lut.sv
// Combinational map from a signed piece byte to its signed material value.
// Magnitudes above the king ID (including -128) are flagged invalid and score 0.
module piece_value_lut
  import chess_pkg::*;
(
  input  logic [7:0]         piece_i,
  output logic signed [31:0] value_o,
  output logic               invalid_o
);

  logic [7:0]         mag;
  logic signed [31:0] base;

  always_comb begin
    mag       = piece_i[7] ? (~piece_i + 8'd1) : piece_i;
    invalid_o = 1'b0;
    base      = '0;
    if (mag > KING_ID) begin
      invalid_o = 1'b1;
    end else if (mag == EMPTY) begin
      base = '0;
    end else if (mag <= PAWN_HI) begin
      base = PAWN_VAL;
    end else if (mag >= ROOK_LO && mag <= ROOK_HI) begin
      base = ROOK_VAL;
    end else if (mag >= KNIGHT_LO && mag <= KNIGHT_HI) begin
      base = KNIGHT_VAL;
    end else if (mag >= BISHOP_LO && mag <= BISHOP_HI) begin
      base = BISHOP_VAL;
    end else if (mag >= QUEEN_LO && mag <= QUEEN_HI) begin
      base = QUEEN_VAL;
    end else begin
      base = KING_VAL;
    end
    value_o = piece_i[7] ? -base : base;
  end

endmodule

// File: rtl/board_eval.sv
// Board material evaluator: reads 64-byte boards over the Avalon master and writes
// one signed score word per board. BOARD_EVAL_BEST_TRACK_EN adds best-score regs 4/5.
module board_eval
  import chess_pkg::*;
#(
  parameter int MAX_BOARDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  localparam int CW = $clog2(MAX_BOARDS + 1);

  state_e             state_q;
  logic [31:0]        boards_base_q, score_base_q, count_reg_q;
  logic [CW-1:0]      count_q, b_q, count_d;
  logic [5:0]         k_q;
  logic [7:0]         byte_q;
  logic signed [31:0] acc_q, acc_d, piece_val;
  logic               piece_bad, done_q, bad_q, host_wr;
  logic               master_read_q, master_write_q;
  logic [31:0]        master_address_q, master_writedata_q;
  logic               unused_readdata;
`ifdef BOARD_EVAL_BEST_TRACK_EN
  logic signed [31:0] best_score_q;
  logic [CW-1:0]      best_idx_q;
`endif

  // 64*b + k and 4*b fall out of plain concatenation since boards are 64 bytes.
  function automatic logic [31:0] board_addr(input logic [31:0] base, input logic [CW-1:0] b,
                                             input logic [5:0] k);
    return base + {{(26-CW){1'b0}}, b, k};
  endfunction

  function automatic logic [31:0] score_addr(input logic [31:0] base, input logic [CW-1:0] b);
    return base + {{(30-CW){1'b0}}, b, 2'b00};
  endfunction

  piece_value_lut u_lut (
    .piece_i   (byte_q),
    .value_o   (piece_val),
    .invalid_o (piece_bad)
  );

  assign acc_d   = acc_q + piece_val;
  assign count_d = (count_reg_q > 32'(MAX_BOARDS)) ? CW'(MAX_BOARDS) : count_reg_q[CW-1:0];

  // Host accesses only complete in IDLE; anything else stalls until the run ends.
  assign slave_waitrequest = (state_q != S_IDLE) && (slave_read || slave_write);
  assign host_wr           = slave_write && (state_q == S_IDLE);

  assign master_read      = master_read_q;
  assign master_write     = master_write_q;
  assign master_address   = master_address_q;
  assign master_writedata = master_writedata_q;
  assign unused_readdata  = ^master_readdata[31:8];

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        REG_CTRL:       slave_readdata = {30'b0, bad_q, done_q};
        REG_BOARD_BASE: slave_readdata = boards_base_q;
        REG_SCORE_BASE: slave_readdata = score_base_q;
        REG_COUNT:      slave_readdata = count_reg_q;
`ifdef BOARD_EVAL_BEST_TRACK_EN
        REG_BEST_SCORE: slave_readdata = best_score_q;
        REG_BEST_IDX:   slave_readdata = {{(32-CW){1'b0}}, best_idx_q};
`endif
        default:        slave_readdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_IDLE;
      boards_base_q      <= '0;
      score_base_q       <= '0;
      count_reg_q        <= '0;
      count_q            <= '0;
      b_q                <= '0;
      k_q                <= '0;
      byte_q             <= '0;
      acc_q              <= '0;
      done_q             <= 1'b0;
      bad_q              <= 1'b0;
      master_read_q      <= 1'b0;
      master_write_q     <= 1'b0;
      master_address_q   <= '0;
      master_writedata_q <= '0;
`ifdef BOARD_EVAL_BEST_TRACK_EN
      best_score_q       <= '0;
      best_idx_q         <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (host_wr) begin
            case (slave_address)
              REG_BOARD_BASE: boards_base_q <= slave_writedata;
              REG_SCORE_BASE: score_base_q  <= slave_writedata;
              REG_COUNT:      count_reg_q   <= slave_writedata;
              default: ;
            endcase
            if (slave_address == REG_CTRL) begin
              done_q  <= 1'b0;
              bad_q   <= 1'b0;
              count_q <= count_d;
              b_q     <= '0;
              k_q     <= '0;
              acc_q   <= '0;
`ifdef BOARD_EVAL_BEST_TRACK_EN
              best_score_q <= '0;
              best_idx_q   <= '0;
`endif
              if (count_d == '0) begin
                state_q <= S_DONE;
              end else begin
                state_q          <= S_RD_REQ;
                master_read_q    <= 1'b1;
                master_address_q <= boards_base_q;
              end
            end
          end
        end
        S_RD_REQ: begin
          if (!master_waitrequest) begin
            master_read_q <= 1'b0;
            state_q       <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (master_readdatavalid) begin
            byte_q  <= master_readdata[7:0];
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc_q <= acc_d;
          if (piece_bad) bad_q <= 1'b1;
          if (k_q != 6'd63) begin
            k_q              <= k_q + 6'd1;
            master_read_q    <= 1'b1;
            master_address_q <= board_addr(boards_base_q, b_q, k_q + 6'd1);
            state_q          <= S_RD_REQ;
          end else begin
            master_write_q     <= 1'b1;
            master_address_q   <= score_addr(score_base_q, b_q);
            master_writedata_q <= acc_d;
            state_q            <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (!master_waitrequest) begin
            master_write_q <= 1'b0;
            state_q        <= S_NEXT;
`ifdef BOARD_EVAL_BEST_TRACK_EN
            // Strict greater-than keeps the lowest index on ties.
            if (b_q == '0 || acc_q > best_score_q) begin
              best_score_q <= acc_q;
              best_idx_q   <= b_q;
            end
`endif
          end
        end
        S_NEXT: begin
          acc_q <= '0;
          k_q   <= '0;
          b_q   <= b_q + CW'(1);
          if ((b_q + CW'(1)) < count_q) begin
            master_read_q    <= 1'b1;
            master_address_q <= board_addr(boards_base_q, b_q + CW'(1), 6'd0);
            state_q          <= S_RD_REQ;
          end else begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_eval.sv
// Self-checking bench for board_eval: SDRAM responder, material-score model with
// write scoreboard, and directed host runs including mid-run reset.
`timescale 1ns/1ps
module tb_board_eval;

  localparam int          MAXB       = 8;
  localparam int          MEM_BYTES  = 64 * MAXB;
  localparam logic [31:0] BOARD_BASE = 32'h0000_1000;
  localparam logic [31:0] SCORE_BASE = 32'h0000_8000;
  localparam int          TIMEOUT    = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = '0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;

  board_eval #(.MAX_BOARDS(MAXB)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  bit          rand_mem = 1'b0;
  logic [7:0]  mem [MEM_BYTES];
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, $signed(act), act,
               $signed(exp), exp);
    end
  endtask

  // ---------------- scoring model ----------------
  function automatic int piece_score(input logic [7:0] p);
    int v, m, s;
    v = int'($signed(p));
    m = (v < 0) ? -v : v;
    if (m > 48) return 0;
    if (m == 0)       s = 0;
    else if (m <= 8)  s = 100;
    else if (m <= 18) s = 500;
    else if (m <= 28) s = 320;
    else if (m <= 38) s = 330;
    else if (m <= 47) s = 900;
    else              s = 20000;
    return (v < 0) ? -s : s;
  endfunction

  function automatic bit piece_bad(input logic [7:0] p);
    int v;
    v = int'($signed(p));
    return (v > 48) || (v < -48);
  endfunction

  function automatic int board_score(input int b);
    int sum = 0;
    for (int i = 0; i < 64; i++) sum += piece_score(mem[b*64+i]);
    return sum;
  endfunction

  function automatic bit board_bad(input int b);
    bit bad = 1'b0;
    for (int i = 0; i < 64; i++) bad |= piece_bad(mem[b*64+i]);
    return bad;
  endfunction

  task automatic clear_board(input int b);
    for (int i = 0; i < 64; i++) mem[b*64+i] = 8'h00;
  endtask

  task automatic load_opening(input int b);
    int back [8] = '{9, 19, 29, 39, 48, 30, 20, 10};
    for (int i = 0; i < 8; i++) begin
      mem[b*64+i]    = 8'(back[i]);
      mem[b*64+8+i]  = 8'(i + 1);
      mem[b*64+48+i] = 8'(-(i + 1));
      mem[b*64+56+i] = 8'(-back[i]);
    end
    for (int i = 16; i < 48; i++) mem[b*64+i] = 8'h00;
  endtask

  // ---------------- SDRAM responder ----------------
  initial begin
    bit          racc, rs, pend;
    int          dly, idx;
    logic [31:0] raddr;
    logic [7:0]  pdata;
    pend = 1'b0; dly = 0; pdata = '0;
    master_waitrequest = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata = '0;
    forever begin
      @(negedge clk);
      racc  = master_read && !master_waitrequest;
      raddr = master_address;
      rs    = rst;
      @(posedge clk); #1;
      master_readdatavalid = 1'b0;
      master_readdata = '0;
      if (rs) begin
        pend = 1'b0;
      end else begin
        if (racc) begin
          idx   = int'(raddr - BOARD_BASE);
          pdata = (idx >= 0 && idx < MEM_BYTES) ? mem[idx] : 8'hEE;
          dly   = rand_mem ? int'($urandom_range(0, 3)) : 0;
          pend  = 1'b1;
        end
        if (pend) begin
          if (dly == 0) begin
            master_readdatavalid = 1'b1;
            master_readdata = {24'hABCDEF, pdata};
            pend = 1'b0;
          end else begin
            dly--;
          end
        end
      end
      master_waitrequest = rand_mem ? ($urandom_range(0, 1) == 1) : 1'b0;
    end
  end

  // ---------------- bus monitor / scoreboard ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if (master_read && master_write) begin
          errors++;
          $display("FAIL strobes: read=%0b write=%0b, required not both high", master_read, master_write);
        end
        if (master_read && !master_waitrequest) begin
          rd_count++;
          if (master_address < BOARD_BASE || master_address >= BOARD_BASE + MEM_BYTES)
            check("rd_addr_range", master_address, BOARD_BASE);
        end
        if (master_write && !master_waitrequest) begin
          wr_count++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr 0x%08h data %0d, required no write",
                     master_address, $signed(master_writedata));
          end else begin
            e = exp_q.pop_front();
            check("score_addr", master_address, e[63:32]);
            check("score_data", master_writedata, e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- host driver tasks ----------------
  task automatic host_write(input logic [3:0] a, input logic [31:0] d);
    int n = 0;
    @(posedge clk); #1;
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    forever begin
      @(negedge clk);
      if (!slave_waitrequest) break;
      if (++n > TIMEOUT) begin
        checks++; errors++;
        $display("FAIL host_write_timeout: reg %0d still stalled after %0d cycles", a, n);
        break;
      end
    end
    @(posedge clk); #1;
    slave_write = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [31:0] d);
    int n = 0;
    @(posedge clk); #1;
    slave_address = a; slave_read = 1'b1;
    d = 'x;
    forever begin
      @(negedge clk);
      if (!slave_waitrequest) begin d = slave_readdata; break; end
      if (++n > TIMEOUT) begin
        checks++; errors++;
        $display("FAIL host_read_timeout: reg %0d still stalled after %0d cycles", a, n);
        break;
      end
    end
    @(posedge clk); #1;
    slave_read = 1'b0;
  endtask

  // One complete run: scoreboard fill, start, blocking status read, traffic and best checks.
  task automatic run_and_check(input string tag, input int req_count);
    int          n;
    int          best, best_idx, s;
    bit          exp_bad;
    logic [31:0] r;
    n = (req_count > MAXB) ? MAXB : req_count;
    exp_bad = 1'b0; best = 0; best_idx = 0;
    rd_count = 0; wr_count = 0;
    for (int b = 0; b < n; b++) begin
      s = board_score(b);
      exp_q.push_back({SCORE_BASE + 32'(4*b), 32'(s)});
      exp_bad |= board_bad(b);
      if (b == 0 || s > best) begin best = s; best_idx = b; end
    end
    host_write(4'd1, BOARD_BASE);
    host_write(4'd2, SCORE_BASE);
    host_write(4'd3, 32'(req_count));
    host_write(4'd0, 32'd1);
    host_read(4'd0, r);
    check({tag, "_status"}, r, {30'b0, exp_bad, 1'b1});
    check({tag, "_reads"}, 32'(rd_count), 32'(64*n));
    check({tag, "_writes"}, 32'(wr_count), 32'(n));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
`ifdef BOARD_EVAL_BEST_TRACK_EN
    host_read(4'd4, r); check({tag, "_best_score"}, r, 32'(best));
    host_read(4'd5, r); check({tag, "_best_idx"}, r, 32'(best_idx));
`else
    host_read(4'd4, r); check({tag, "_reg4"}, r, 32'd0);
    host_read(4'd5, r); check({tag, "_reg5"}, r, 32'd0);
`endif
  endtask

  task automatic check_reset_state(input string tag);
    logic [31:0] r;
    @(negedge clk);
    check({tag, "_mread"}, 32'(master_read), 32'd0);
    check({tag, "_mwrite"}, 32'(master_write), 32'd0);
    check({tag, "_maddr"}, master_address, 32'd0);
    check({tag, "_mwdata"}, master_writedata, 32'd0);
    check({tag, "_swait"}, 32'(slave_waitrequest), 32'd0);
    host_read(4'd0, r); check({tag, "_reg0"}, r, 32'd0);
    host_read(4'd1, r); check({tag, "_reg1"}, r, 32'd0);
    host_read(4'd2, r); check({tag, "_reg2"}, r, 32'd0);
    host_read(4'd3, r); check({tag, "_reg3"}, r, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] r;
    for (int b = 0; b < MAXB; b++) clear_board(b);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    // Opening position scores zero.
    load_opening(0);
    check("pin_opening", 32'(board_score(0)), 32'd0);
    run_and_check("opening", 1);
    host_read(4'd1, r); check("readback_reg1", r, BOARD_BASE);

    // White king + black queen, then lone black king.
    clear_board(0); clear_board(1); load_opening(2);
    mem[0] = 8'h30; mem[10] = 8'hD9;
    mem[64 + 5] = 8'hD0;
    check("pin_king_queen", 32'(board_score(0)), 32'sd19100);
    check("pin_black_king", 32'(board_score(1)), -32'sd20000);
    run_and_check("two_boards", 2);

    // Same boards plus the opening under a stalling, slow memory.
    rand_mem = 1'b1;
    run_and_check("stall_mem", 3);
    rand_mem = 1'b0;

    run_and_check("count_zero", 0);

    // Out-of-range bytes are excluded from the score and flagged.
    clear_board(0);
    mem[3] = 8'h40; mem[4] = 8'h01; mem[5] = 8'h80;
    check("pin_bad_board", 32'(board_score(0)), 32'd100);
    run_and_check("bad_piece", 1);

    // Request above the limit saturates to MAXB boards.
    for (int b = 1; b < MAXB; b++) mem[b*64 + b] = 8'(b * 6);
    run_and_check("saturate", 10);

    // Abandon a run mid-board; no write may follow the reset.
    load_opening(0); load_opening(1);
    host_write(4'd1, BOARD_BASE);
    host_write(4'd2, SCORE_BASE);
    host_write(4'd3, 32'd2);
    host_write(4'd0, 32'd1);
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    check_reset_state("mid_reset");

    clear_board(0); clear_board(1); clear_board(2);
    mem[7] = 8'hFF;
    mem[64] = 8'h01; mem[65] = 8'h02; mem[66] = 8'h03;
    mem[128] = 8'h09; mem[129] = 8'hFF; mem[130] = 8'hFE;
    check("pin_best_b0", 32'(board_score(0)), -32'sd100);
    check("pin_best_b1", 32'(board_score(1)), 32'd300);
    check("pin_best_b2", 32'(board_score(2)), 32'd300);
    rand_mem = 1'b1;
    run_and_check("after_reset", 3);
    rand_mem = 1'b0;
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
